// File: rtl/tetris_stat_pkg.sv
// Shared types and constants for the statistics display character streamer.
package tetris_stat_pkg;

  localparam int unsigned STAT_DIGITS        = 6;
  localparam logic [3:0]  BLANK_CODE_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ROW_SCORE = 2'd0,
    ROW_LINES = 2'd1,
    ROW_LEVEL = 2'd2
  } row_e;

  // One character request towards the drawer.
  typedef struct packed {
    logic [3:0] code;
    row_e       row;
    logic [2:0] col;
  } char_req_t;

  function automatic row_e next_row(input row_e r);
    case (r)
      ROW_SCORE: next_row = ROW_LINES;
      ROW_LINES: next_row = ROW_LEVEL;
      default:   next_row = ROW_LEVEL;
    endcase
  endfunction

endpackage

// File: rtl/bcd_lzb.sv
// Leading-zero blank mask for one BCD row; bit c of blank_o covers column c
// (column 0 = most-significant digit). The last column is never blanked.
module bcd_lzb #(
  parameter int unsigned DIGITS = 6
) (
  input  logic [4*DIGITS-1:0] bcd_i,
  output logic [DIGITS-1:0]   blank_o
);

  logic seen_nz;

  always_comb begin
    blank_o = '0;
    seen_nz = 1'b0;
    for (int c = 0; c < int'(DIGITS) - 1; c++) begin
      if (bcd_i[4*(int'(DIGITS)-1-c) +: 4] != 4'd0) seen_nz = 1'b1;
      blank_o[c] = ~seen_nz;
    end
  end

endmodule

// File: rtl/tetris_stat_disp.sv
// Streams the score/lines/level rows as per-digit character requests to a drawer.
// Define TETRIS_STAT_DISP_LZB_EN to enable leading-zero blanking.
module tetris_stat_disp
  import tetris_stat_pkg::*;
#(
  parameter logic [3:0]  BLANK_CODE = BLANK_CODE_DEFAULT,
  parameter int unsigned DIGITS     = STAT_DIGITS
) (
  input  logic                clk,
  input  logic                srst_n,
  input  logic [4*DIGITS-1:0] score_i,
  input  logic [4*DIGITS-1:0] lines_i,
  input  logic [4*DIGITS-1:0] level_i,
  input  logic                update_i,
  input  logic                level_changed_i,
  output logic                char_valid_o,
  input  logic                char_ready_i,
  output logic [3:0]          char_code_o,
  output logic [1:0]          char_row_o,
  output logic [2:0]          char_col_o,
  output logic                busy_o,
  output logic                frame_done_o
);

  localparam int unsigned W        = 4 * DIGITS;
  localparam logic [2:0]  LAST_COL = 3'(DIGITS - 1);

  state_e    state_q, state_d;
  logic      pending_q, pending_d;
  logic [W-1:0] score_q, score_d;
  logic [W-1:0] lines_q, lines_d;
  logic [W-1:0] level_q, level_d;
  char_req_t char_q, char_d;
  logic      valid_q, valid_d;
  logic      busy_q, busy_d;
  logic      done_q, done_d;

  logic         start_c, xfer_c, last_c, present_c;
  row_e         pos_row_c;
  logic [2:0]   pos_col_c;
  logic [W-1:0] row_bcd_c;
  logic [DIGITS-1:0] blank_c;
  logic [3:0]   digit_c;
  logic         blank_sel_c;

  assign start_c = update_i | level_changed_i;
  assign xfer_c  = valid_q & char_ready_i;
  assign last_c  = (char_q.row == ROW_LEVEL) && (char_q.col == LAST_COL);

  // Sequencing; present_c requests a new character at pos_row_c/pos_col_c.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | start_c;
    score_d   = score_q;
    lines_d   = lines_q;
    level_d   = level_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    present_c = 1'b0;
    pos_row_c = ROW_SCORE;
    pos_col_c = 3'd0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          state_d   = ST_LOAD;
          pending_d = 1'b0;
        end
      end
      ST_LOAD: begin
        score_d   = score_i;
        lines_d   = lines_i;
        level_d   = level_i;
        state_d   = ST_SEND;
        valid_d   = 1'b1;
        present_c = 1'b1;
      end
      ST_SEND: begin
        if (xfer_c) begin
          if (last_c) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            present_c = 1'b1;
            if (char_q.col == LAST_COL) begin
              pos_row_c = next_row(char_q.row);
              pos_col_c = 3'd0;
            end else begin
              pos_row_c = char_q.row;
              pos_col_c = char_q.col + 3'd1;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Row source is the next-cycle shadow, so the LOAD snapshot feeds the first character.
  always_comb begin
    case (pos_row_c)
      ROW_LINES: row_bcd_c = lines_d;
      ROW_LEVEL: row_bcd_c = level_d;
      default:   row_bcd_c = score_d;
    endcase
  end

`ifdef TETRIS_STAT_DISP_LZB_EN
  bcd_lzb #(
    .DIGITS (DIGITS)
  ) u_lzb (
    .bcd_i   (row_bcd_c),
    .blank_o (blank_c)
  );
`else
  assign blank_c = '0;
`endif

  always_comb begin
    digit_c     = 4'd0;
    blank_sel_c = 1'b0;
    for (int c = 0; c < int'(DIGITS); c++) begin
      if (pos_col_c == 3'(c)) begin
        digit_c     = row_bcd_c[4*(int'(DIGITS)-1-c) +: 4];
        blank_sel_c = blank_c[c];
      end
    end
    char_d = char_q;
    if (present_c) begin
      char_d.row  = pos_row_c;
      char_d.col  = pos_col_c;
      char_d.code = blank_sel_c ? BLANK_CODE : digit_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b1;
      score_q   <= '0;
      lines_q   <= '0;
      level_q   <= '0;
      char_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      score_q   <= score_d;
      lines_q   <= lines_d;
      level_q   <= level_d;
      char_q    <= char_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign char_valid_o = valid_q;
  assign char_code_o  = char_q.code;
  assign char_row_o   = char_q.row;
  assign char_col_o   = char_q.col;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_tetris_stat_disp.sv
// Randomized self-checking bench for tetris_stat_disp with a frame-level reference model.
module tb_tetris_stat_disp;

  typedef struct packed {
    logic [3:0] code;
    logic [1:0] row;
    logic [2:0] col;
  } chr_t;

`ifdef TETRIS_STAT_DISP_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        srst_n;
  logic [23:0] score_i, lines_i, level_i;
  logic        update_i, level_changed_i;
  logic        char_valid_o, char_ready_i;
  logic [3:0]  char_code_o;
  logic [1:0]  char_row_o;
  logic [2:0]  char_col_o;
  logic        busy_o, frame_done_o;

  chr_t obs_q[$];
  chr_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  tetris_stat_disp dut (
    .clk             (clk),
    .srst_n          (srst_n),
    .score_i         (score_i),
    .lines_i         (lines_i),
    .level_i         (level_i),
    .update_i        (update_i),
    .level_changed_i (level_changed_i),
    .char_valid_o    (char_valid_o),
    .char_ready_i    (char_ready_i),
    .char_code_o     (char_code_o),
    .char_row_o      (char_row_o),
    .char_col_o      (char_col_o),
    .busy_o          (busy_o),
    .frame_done_o    (frame_done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic chr_t cur();
    chr_t c;
    c.code = char_code_o;
    c.row  = char_row_o;
    c.col  = char_col_o;
    return c;
  endfunction

  // Expected frame: rows in order, digits left to right, optional leading-zero blanking.
  function automatic void build_exp(input logic [23:0] s, input logic [23:0] l, input logic [23:0] v);
    logic [23:0] val;
    logic [3:0]  d;
    bit          leading;
    chr_t        e;
    exp_q.delete();
    for (int r = 0; r < 3; r++) begin
      val     = (r == 0) ? s : ((r == 1) ? l : v);
      leading = 1'b1;
      for (int c = 0; c < 6; c++) begin
        d = val[4*(5-c) +: 4];
        if (LZB && leading && d == 4'd0 && c != 5) e.code = 4'hF;
        else begin
          e.code = d;
          if (d != 4'd0) leading = 1'b0;
        end
        e.row = 2'(r);
        e.col = 3'(c);
        exp_q.push_back(e);
      end
    end
  endfunction

  function automatic logic [23:0] rand_bcd();
    logic [23:0] v;
    int z;
    v = 24'($urandom);
    z = $urandom_range(0, 6);
    for (int c = 0; c < z; c++) v[4*(5-c) +: 4] = 4'd0;
    return v;
  endfunction

  task automatic kick(input bit use_level);
    @(negedge clk);
    if (use_level) level_changed_i = 1'b1;
    else           update_i        = 1'b1;
  endtask

  // Records accepted characters into obs_q until frame_done_o is seen.
  task automatic collect(input int budget, input bit rand_ready, input int pulse_a, input int pulse_b,
                         input logic [23:0] score_b, input bit pulse_last,
                         output int ndone, output bit timed_out);
    ndone     = 0;
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      update_i        = 1'b0;
      level_changed_i = 1'b0;
      if (frame_done_o) begin
        ndone++;
        timed_out = 1'b0;
        break;
      end
      char_ready_i = rand_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
      if (char_valid_o && char_ready_i) begin
        obs_q.push_back(cur());
        if (pulse_last && char_row_o == 2'd2 && char_col_o == 3'd5) update_i = 1'b1;
      end
      if (k == pulse_a || k == pulse_b) update_i = 1'b1;
      if (k == pulse_b) score_i = score_b;
    end
  endtask

  task automatic test_reset();
    int nd; bit tmo;
    srst_n = 1'b0; char_ready_i = 1'b1;
    score_i = '0; lines_i = '0; level_i = '0;
    update_i = 1'b0; level_changed_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (char_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", char_valid_o); end
    checks++; if (char_code_o !== 4'd0) begin failures++; $display("FAIL rst_code got=%h exp=0", char_code_o); end
    checks++; if (char_row_o !== 2'd0) begin failures++; $display("FAIL rst_row got=%0d exp=0", char_row_o); end
    checks++; if (char_col_o !== 3'd0) begin failures++; $display("FAIL rst_col got=%0d exp=0", char_col_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy_o); end
    checks++; if (frame_done_o !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", frame_done_o); end
    obs_q.delete(); build_exp(24'h0, 24'h0, 24'h0);
    srst_n = 1'b1;
    collect(80, 1'b0, -1, -1, 24'h0, 1'b0, nd, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL rst_frame_timeout got=1 exp=0"); end
    checks++; if (obs_q.size() != 18) begin failures++; $display("FAIL rst_frame_count got=%0d exp=18", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 18; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rst_frame_char[%0d] got=%h/%0d/%0d exp=%h/%0d/%0d", i, obs_q[i].code, obs_q[i].row,
                 obs_q[i].col, exp_q[i].code, exp_q[i].row, exp_q[i].col);
      end
    end
    checks++; if (nd != 1) begin failures++; $display("FAIL rst_frame_done got=%0d exp=1", nd); end
  endtask

  task automatic test_latency();
    int nd; bit tmo;
    repeat (2) @(negedge clk);
    score_i = 24'h001200; lines_i = 24'h000012; level_i = 24'h000002;
    char_ready_i = 1'b0;
    obs_q.delete(); build_exp(score_i, lines_i, level_i);
    kick(1'b0);
    @(negedge clk); update_i = 1'b0;
    checks++; if (char_valid_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL lat_edge1 got=v%b/b%b exp=v0/b0", char_valid_o, busy_o); end
    @(negedge clk);
    checks++; if (char_valid_o !== 1'b0 || busy_o !== 1'b1) begin failures++; $display("FAIL lat_edge2 got=v%b/b%b exp=v0/b1", char_valid_o, busy_o); end
    @(negedge clk);
    checks++; if (char_valid_o !== 1'b1) begin failures++; $display("FAIL lat_edge3_valid got=%b exp=1", char_valid_o); end
    checks++; if (cur() !== exp_q[0]) begin failures++; $display("FAIL lat_first_char got=%h exp=%h", cur(), exp_q[0]); end
    collect(200, 1'b1, -1, -1, 24'h0, 1'b0, nd, tmo);
    checks++; if (tmo) begin failures++; $display("FAIL lat_timeout got=1 exp=0"); end
    checks++; if (obs_q.size() != 18) begin failures++; $display("FAIL lat_count got=%0d exp=18", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 18; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL lat_char[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int nd; bit tmo; bit found; chr_t hold;
    repeat (2) @(negedge clk);
    score_i = 24'h123456; lines_i = 24'h000789; level_i = 24'h000010;
    obs_q.delete(); build_exp(score_i, lines_i, level_i);
    char_ready_i = 1'b1;
    kick(1'b0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk); update_i = 1'b0;
      if (char_valid_o && char_row_o == 2'd0 && char_col_o == 3'd3) begin
        found = 1'b1; hold = cur(); char_ready_i = 1'b0;
      end else if (char_valid_o) obs_q.push_back(cur());
    end
    checks++; if (!found) begin failures++; $display("FAIL bp_reach_col3 got=0 exp=1"); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (char_valid_o !== 1'b1 || cur() !== hold) begin
        failures++;
        $display("FAIL bp_stall[%0d] got=v%b/%h exp=v1/%h", k, char_valid_o, cur(), hold);
      end
    end
    collect(80, 1'b0, -1, -1, 24'h0, 1'b0, nd, tmo);
    checks++; if (tmo || nd != 1) begin failures++; $display("FAIL bp_done got=%0d exp=1", nd); end
    checks++; if (obs_q.size() != 18) begin failures++; $display("FAIL bp_count got=%0d exp=18", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 18; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_char[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int nd; bit tmo;
    for (int it = 0; it < 5; it++) begin
      repeat (2) @(negedge clk);
      score_i = rand_bcd(); lines_i = rand_bcd(); level_i = rand_bcd();
      obs_q.delete(); build_exp(score_i, lines_i, level_i);
      kick(1'($urandom_range(0, 1)));
      collect(300, 1'b1, -1, -1, 24'h0, 1'b0, nd, tmo);
      checks++; if (tmo || nd != 1) begin failures++; $display("FAIL rnd%0d_done got=%0d exp=1", it, nd); end
      checks++; if (obs_q.size() != 18) begin failures++; $display("FAIL rnd%0d_count got=%0d exp=18", it, obs_q.size()); end
      for (int i = 0; i < obs_q.size() && i < 18; i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd%0d_char[%0d] got=%h exp=%h", it, i, obs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int nd; bit tmo; bit seen;
    repeat (2) @(negedge clk);
    score_i = 24'h004500; lines_i = rand_bcd(); level_i = rand_bcd();
    obs_q.delete(); build_exp(score_i, lines_i, level_i);
    kick(1'b0);
    collect(80, 1'b0, 3, 8, 24'h000300, 1'b0, nd, tmo);
    checks++; if (tmo || nd != 1) begin failures++; $display("FAIL b2b_f1_done got=%0d exp=1", nd); end
    checks++; if (obs_q.size() != 18) begin failures++; $display("FAIL b2b_f1_count got=%0d exp=18", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 18; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_f1_char[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); build_exp(24'h000300, lines_i, level_i);
    collect(80, 1'b0, -1, -1, 24'h0, 1'b0, nd, tmo);
    checks++; if (tmo || nd != 1) begin failures++; $display("FAIL b2b_f2_done got=%0d exp=1", nd); end
    checks++; if (obs_q.size() != 18) begin failures++; $display("FAIL b2b_f2_count got=%0d exp=18", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 18; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_f2_char[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (char_valid_o || busy_o) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL b2b_no_third_frame got=active exp=idle"); end
  endtask

  task automatic test_last_overlap();
    int nd; bit tmo;
    repeat (2) @(negedge clk);
    score_i = rand_bcd(); lines_i = rand_bcd(); level_i = rand_bcd();
    obs_q.delete(); build_exp(score_i, lines_i, level_i);
    kick(1'b0);
    collect(300, 1'b1, -1, -1, 24'h0, 1'b1, nd, tmo);
    checks++; if (tmo || nd != 1) begin failures++; $display("FAIL ovl_f1_done got=%0d exp=1", nd); end
    checks++; if (obs_q.size() != 18) begin failures++; $display("FAIL ovl_f1_count got=%0d exp=18", obs_q.size()); end
    score_i = rand_bcd();
    obs_q.delete(); build_exp(score_i, lines_i, level_i);
    collect(300, 1'b1, -1, -1, 24'h0, 1'b0, nd, tmo);
    checks++; if (tmo || nd != 1) begin failures++; $display("FAIL ovl_f2_done got=%0d exp=1", nd); end
    checks++; if (obs_q.size() != 18) begin failures++; $display("FAIL ovl_f2_count got=%0d exp=18", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 18; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovl_f2_char[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int nd; int n; bit tmo; bit hit; bit done_seen;
    repeat (2) @(negedge clk);
    score_i = rand_bcd(); lines_i = rand_bcd(); level_i = rand_bcd();
    char_ready_i = 1'b1;
    kick(1'b0);
    n = 0; hit = 1'b0; done_seen = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk); update_i = 1'b0;
      if (frame_done_o) done_seen = 1'b1;
      if (char_valid_o) begin
        n++;
        if (n == 7) begin srst_n = 1'b0; hit = 1'b1; end
      end
    end
    checks++; if (!hit) begin failures++; $display("FAIL rmid_reach7 got=%0d exp=7", n); end
    @(negedge clk);
    if (frame_done_o) done_seen = 1'b1;
    checks++; if (char_valid_o !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", char_valid_o); end
    checks++; if (busy_o !== 1'b0 || char_code_o !== 4'd0) begin failures++; $display("FAIL rmid_state got=b%b/c%h exp=b0/c0", busy_o, char_code_o); end
    srst_n = 1'b1;
    obs_q.delete(); build_exp(score_i, lines_i, level_i);
    collect(80, 1'b0, -1, -1, 24'h0, 1'b0, nd, tmo);
    checks++; if (done_seen) begin failures++; $display("FAIL rmid_abort_done got=1 exp=0"); end
    checks++; if (tmo || nd != 1) begin failures++; $display("FAIL rmid_done got=%0d exp=1", nd); end
    checks++; if (obs_q.size() != 18) begin failures++; $display("FAIL rmid_count got=%0d exp=18", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 18; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rmid_char[%0d] got=%h exp=%h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_last_overlap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
